bus_arb2: RTL
=============

# bus_arb2

Two-port master arbiter for the internal register bus. Accepts single read/write transactions from two requesters (e.g. host bridge on port 0, on-chip sequencer on port 1), grants them round-robin, and drives one bus strobe per transaction. It then waits for the registered read/write acknowledge from the addressed slave and returns data, or an error on timeout. All register slaves, including masked-write registers, sit downstream of this block.

## Interface
- ADDRWIDTH, 16, bus address width (byte address; slaves decode bits [ADDRWIDTH-1:2])
- DATAWIDTH, 32, bus data width (masked registers use [31:16] as write mask)
- TIMEOUT, 255, WAIT cycles before abort (1..1023)

Ports (one clock; reset is asynchronous and active-low):
- bus_clk  in  1  bus clock
- bus_reset_l  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request, level; held with fields stable until m0_done
- m0_we  in  1  1=write, 0=read
- m0_addr  in  ADDRWIDTH  transaction address
- m0_wr_data  in  DATAWIDTH  write data
- m0_done  out  1  one-cycle completion pulse
- m0_rd_data  out  DATAWIDTH  read data, valid with m0_done
- m0_err  out  1  timeout flag, valid with m0_done
- m1_*  same set for port 1
- bus_addr  out  ADDRWIDTH  address to slaves
- bus_re  out  1  one-cycle read strobe
- bus_we  out  1  one-cycle write strobe
- bus_wr_data  out  DATAWIDTH  write data to slaves
- bus_rd_data  in  DATAWIDTH  OR of slave read data (zero when not acking)
- bus_rd_ack  in  1  OR of slave read acks
- bus_wr_ack  in  1  OR of slave write acks
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, select the grantee, latch its we/addr/wr_data into bus_* registers, and go to ISSUE. Otherwise stay.
- Arbitration: round-robin on last_grant. With both reqs high, the port that is not last_grant wins. last_grant resets to 1, so port 0 wins the first contest. last_grant updates on grant.
- ISSUE: bus_re (read) or bus_we (write) high for exactly this cycle. Timeout counter is cleared. Go to WAIT, or straight to DONE if the matching ack is already high.
- WAIT: strobes low, bus_addr and bus_wr_data held. On the matching ack (bus_rd_ack for reads, bus_wr_ack for writes), capture bus_rd_data (reads) and go to DONE with err=0. If the counter reaches TIMEOUT, go to DONE with err=1 and rd_data=0. Otherwise increment the counter.
- DONE: the grantee's done is high for one cycle, with rd_data/err valid. The other port's done stays low. Go to IDLE.
- Read data output is held stable until the next completion on that port. Err is valid only with done.
- The non-matching ack type is ignored. Acks in IDLE or DONE (late or stale) are ignored.
- A requester that keeps req high after seeing done is treated as issuing a new transaction.
- Counter width is ceil(log2(TIMEOUT+1)). It saturates and never wraps.

## Timing
- Reset (async assert, sync release): state=IDLE, last_grant=1, counter=0, and every output is 0 (bus_addr, bus_wr_data, bus_re, bus_we, m*_done, m*_rd_data, m*_err, busy).
- Reset mid-transaction aborts with no done pulse. A strobe in flight drops immediately.
- Best-case latency, with a registered slave acking the cycle after its strobe:
  - req seen in IDLE at edge 0
  - ISSUE cycle 1 (strobe)
  - ack sampled in WAIT cycle 2
  - done cycle 3
- Back-to-back latency is 4 cycles per transaction.
- Timeout: done with err arrives TIMEOUT+2 cycles after ISSUE.
- With both ports requesting continuously, grants strictly alternate: 0,1,0,1,...

## Test plan
- Single read, port 0 only: read addr 0x0010, slave acks 1 cycle after bus_re with data 0x0000_1234 -> bus_re pulse of exactly 1 cycle, m0_done 3 cycles after req, m0_rd_data=0x1234, m0_err=0.
- Masked write, port 1: m1_we=1, addr 0x0020, data 0x00FF_00A5 -> bus_we one cycle with bus_wr_data=0x00FF_00A5, m1_done after wr_ack, m1_err=0.
- Contention: both reqs asserted together out of reset, held high across 4 transactions -> grant order 0,1,0,1, and each done appears only on the granted port.
- Timeout: read an unmapped address (no ack), TIMEOUT=8 -> m0_done with m0_err=1 and m0_rd_data=0 exactly 10 cycles after the bus_re cycle; a late ack arriving in IDLE is ignored.
- Wrong ack type: write transaction receives only a bus_rd_ack pulse -> ignored, the transaction times out with err=1.
- Reset in WAIT: assert bus_reset_l low mid-read -> all outputs 0 asynchronously, no done pulse. After release, a fresh port 0 read completes normally.

Source files
------------

// File: rtl/bus_arb2.sv
// bus_arb2: two-port round-robin master for the internal register bus.
// Issues one strobe per granted transaction, then waits for the matching ack or a timeout.
module bus_arb2 #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset_l,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDRWIDTH-1:0] m0_addr,
    input  logic [DATAWIDTH-1:0] m0_wr_data,
    output logic                 m0_done,
    output logic [DATAWIDTH-1:0] m0_rd_data,
    output logic                 m0_err,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDRWIDTH-1:0] m1_addr,
    input  logic [DATAWIDTH-1:0] m1_wr_data,
    output logic                 m1_done,
    output logic [DATAWIDTH-1:0] m1_rd_data,
    output logic                 m1_err,
    output logic [ADDRWIDTH-1:0] bus_addr,
    output logic                 bus_re,
    output logic                 bus_we,
    output logic [DATAWIDTH-1:0] bus_wr_data,
    input  logic [DATAWIDTH-1:0] bus_rd_data,
    input  logic                 bus_rd_ack,
    input  logic                 bus_wr_ack,
    output logic                 busy
);
    // state | meaning
    // IDLE  | no transaction; arbitrate on req
    // ISSUE | read or write strobe on the bus for this one cycle
    // WAIT  | strobes low, waiting for the matching ack or timeout
    // DONE  | grantee sees its one-cycle done pulse
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [1:0]           state;
    logic                 last_grant;
    logic                 grant;
    logic                 we_q;
    logic [CNT_W-1:0]     cnt;
    logic                 pick;
    logic                 pick_we;
    logic                 ack_hit;
    logic                 cnt_hit;
    logic                 fin;
    logic                 fin_err;
    logic [DATAWIDTH-1:0] fin_data;

    // With both requesting, the port that did not win last time goes next.
    assign pick     = (m0_req & m1_req) ? ~last_grant : m1_req;
    assign pick_we  = pick ? m1_we : m0_we;
    assign ack_hit  = we_q ? bus_wr_ack : bus_rd_ack;
    assign cnt_hit  = (cnt == CNT_MAX);
    assign fin      = ((state == ST_ISSUE) & ack_hit) |
                      ((state == ST_WAIT) & (ack_hit | cnt_hit));
    assign fin_err  = (state == ST_WAIT) & ~ack_hit & cnt_hit;
    assign fin_data = fin_err ? '0 : bus_rd_data;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            we_q        <= 1'b0;
            cnt         <= '0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            bus_re      <= 1'b0;
            bus_we      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req | m1_req) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        we_q        <= pick_we;
                        bus_addr    <= pick ? m1_addr : m0_addr;
                        bus_wr_data <= pick ? m1_wr_data : m0_wr_data;
                        bus_re      <= ~pick_we;
                        bus_we      <= pick_we;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus_re <= 1'b0;
                    bus_we <= 1'b0;
                    cnt    <= '0;
                    state  <= fin ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (fin) begin
                        state <= ST_DONE;
                    end else if (!cnt_hit) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data only moves on a read completion or a timeout; writes leave it alone.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
        end else begin
            m0_done <= fin & ~grant;
            m1_done <= fin & grant;
            m0_err  <= fin & ~grant & fin_err;
            m1_err  <= fin & grant & fin_err;
            if (fin & ~grant & (~we_q | fin_err)) begin
                m0_rd_data <= fin_data;
            end
            if (fin & grant & (~we_q | fin_err)) begin
                m1_rd_data <= fin_data;
            end
        end
    end

endmodule
